square_gen: RTL and testbench



---
 rtl/square_gen.sv | 204 ++++++++++++++++++++
 tb/tb_square_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_gen.sv
// square_gen: BCD frequency setpoint -> binary -> clock divider -> registered 50% square wave.
// Latency load->done: 1 + 1 + DIGITS + CNT_W + 1 cycles (DIV skipped when the setpoint is 0).
// No backpressure: load is ignored while busy. Optional macro ROUND_EN makes the divide round (ties up) instead of truncate.
module square_gen #(
    parameter int CLK_HZ = 6_000_000,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 28
) (
    input  logic                  clk_6M,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_freq,
    output logic                  busy,
    output logic                  done,
    output logic                  bcd_err,
    output logic                  square
);

    localparam int MAX_STEPS = (CNT_W > DIGITS) ? CNT_W : DIGITS;
    localparam int STEP_W    = $clog2(MAX_STEPS + 1);

    localparam logic [STEP_W-1:0] LAST_DIG = STEP_W'(DIGITS - 1);
    localparam logic [STEP_W-1:0] LAST_DIV = STEP_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0]  N_BASE   = CNT_W'(CLK_HZ);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        B2B,
        DIV,
        APPLY
    } state_t;

    state_t               state;
    logic [4*DIGITS-1:0]  bcd_lat;    // setpoint, shifted left one digit per B2B cycle
    logic [CNT_W-1:0]     bin;        // binary frequency accumulator
    logic [CNT_W-1:0]     den;        // divisor 2*bin, frozen for the whole divide
    logic [CNT_W-1:0]     rem;        // restoring-division partial remainder
    logic [CNT_W-1:0]     quo;        // dividend shifts out the top, quotient shifts in the bottom
    logic [STEP_W-1:0]    step;
    logic [CNT_W-1:0]     half_new;   // result handed to the generator in APPLY

    logic [CNT_W-1:0]     half_reg;   // active half-period, 0 = stopped
    logic [CNT_W-1:0]     half_pend;  // half-period waiting for the next wrap
    logic [CNT_W-1:0]     tc;

    logic                 bcd_bad;
    logic [3:0]           digit;
    logic [CNT_W-1:0]     bin_nxt;
    logic [CNT_W-1:0]     rem_low;
    logic                 rem_ge;
    logic [CNT_W-1:0]     rem_nxt;
    logic [CNT_W-1:0]     quo_nxt;
    logic                 apply;
    logic [CNT_W-1:0]     pend_val;
    logic                 wrap;

    // Flag any nibble of the latched setpoint that is not a decimal digit
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_lat[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // Datapath for one BCD->binary step and one restoring-division step
    always_comb begin
        digit   = bcd_lat[4*DIGITS-1 -: 4];
        // bin*10 built from two shifts; no multiplier
        bin_nxt = (bin << 3) + (bin << 1) + CNT_W'(digit);

        // Remainder is always < den, so when its MSB is set the shifted value
        // exceeds 2^CNT_W > den; the CNT_W-bit subtraction is still exact.
        rem_low = {rem[CNT_W-2:0], quo[CNT_W-1]};
        rem_ge  = rem[CNT_W-1] | (rem_low >= den);
        rem_nxt = rem_ge ? (rem_low - den) : rem_low;
        quo_nxt = {quo[CNT_W-2:0], rem_ge};
    end

    // Control FSM: latch, validate, convert, divide, hand result to the generator
    always_ff @(posedge clk_6M or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_err  <= 1'b0;
            bcd_lat  <= '0;
            bin      <= '0;
            den      <= '0;
            rem      <= '0;
            quo      <= '0;
            step     <= '0;
            half_new <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bcd_lat <= bcd_freq;
                        bcd_err <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (bcd_bad) begin
                        // Generator keeps running on its previous setting
                        bcd_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bin   <= '0;
                        step  <= '0;
                        state <= B2B;
                    end
                end
                B2B: begin
                    bin     <= bin_nxt;
                    bcd_lat <= bcd_lat << 4;
                    if (step == LAST_DIG) begin
                        step <= '0;
                        if (bin_nxt == '0) begin
                            // 0 Hz: stop the output, no divide needed
                            half_new <= '0;
                            done     <= 1'b1;
                            state    <= APPLY;
                        end else begin
                            den <= bin_nxt << 1;
                            rem <= '0;
`ifdef ROUND_EN
                            // Adding bin (half the divisor) turns truncation into round-half-up
                            quo <= N_BASE + bin_nxt;
`else
                            quo <= N_BASE;
`endif
                            state <= DIV;
                        end
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (step == LAST_DIV) begin
                        step     <= '0;
                        // A zero quotient would stop the output; clamp to the fastest wave
                        half_new <= (quo_nxt == '0) ? CNT_W'(1) : quo_nxt;
                        done     <= 1'b1;
                        state    <= APPLY;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                APPLY: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign apply    = (state == APPLY);
    // A write landing on the same cycle as a wrap takes effect at that wrap
    assign pend_val = apply ? half_new : half_pend;
    assign wrap     = (half_reg != '0) && (tc == (half_reg - CNT_W'(1)));

    // Toggle generator; new half-periods are adopted only at a wrap so no short pulses appear
    always_ff @(posedge clk_6M or posedge reset) begin
        if (reset) begin
            half_reg  <= '0;
            half_pend <= '0;
            tc        <= '0;
            square    <= 1'b0;
        end else begin
            if (apply) begin
                half_pend <= half_new;
            end
            if (half_reg == '0) begin
                tc     <= '0;
                square <= 1'b0;
                // Stopped: nothing to finish, so start right away with a rising edge
                if (apply && (half_new != '0)) begin
                    half_reg <= half_new;
                    square   <= 1'b1;
                end
            end else if (wrap) begin
                tc       <= '0;
                half_reg <= pend_val;
                // Stopping forces the line low rather than toggling it
                square   <= (pend_val == '0) ? 1'b0 : ~square;
            end else begin
                tc <= tc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_square_gen.sv
// Bench for square_gen: stimulus pushes expectations, a negedge monitor compares them.
// The divider numerator is scaled to 60 kHz so wave periods stay short; the divide path is unchanged.
// Latency is counted inclusively: the cycle load is high is cycle 1, the done cycle is the last.
module tb_square_gen;

    localparam int CLK_HZ = 60_000;
    localparam int DIGITS = 3;
    localparam int CNT_W  = 28;
    localparam int LAT    = 1 + 1 + DIGITS + CNT_W + 1;   // 34
    localparam int LAT0   = 1 + 1 + DIGITS + 1;           // 6, divide skipped

`ifdef ROUND_EN
    localparam int H17 = 1765;   // (60000+17)/34
`else
    localparam int H17 = 1764;   // 60000/34 truncated
`endif

    logic        clk_6M = 1'b0;
    logic        reset  = 1'b1;
    logic        load   = 1'b0;
    logic [11:0] bcd_freq = '0;
    logic        busy, done, bcd_err, square;

    square_gen #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
        .clk_6M   (clk_6M),
        .reset    (reset),
        .load     (load),
        .bcd_freq (bcd_freq),
        .busy     (busy),
        .done     (done),
        .bcd_err  (bcd_err),
        .square   (square)
    );

    always #5 clk_6M = ~clk_6M;

    typedef struct { int exp; int load_cyc; } lat_t;
    typedef struct { int exp; int arm; } meas_t;
    typedef struct { string name; int sig; int exp; int at; } smp_t;

    lat_t  lat_q[$];
    meas_t hi_q[$];
    meas_t lo_q[$];
    int    start_q[$];
    smp_t  smp_q[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int sig_val(int s);
        case (s)
            0:       return int'(square);
            1:       return int'(busy);
            2:       return int'(bcd_err);
            default: return int'(done);
        endcase
    endfunction

    function automatic void smp(string nm, int sig, int exp, int at);
        smp_t s;
        s.name = nm; s.sig = sig; s.exp = exp; s.at = at;
        smp_q.push_back(s);
    endfunction

    function automatic void push_lat(int exp, int lc);
        lat_t l;
        l.exp = exp; l.load_cyc = lc;
        lat_q.push_back(l);
    endfunction

    function automatic void push_hi(int exp, int arm);
        meas_t x;
        x.exp = exp; x.arm = arm;
        hi_q.push_back(x);
    endfunction

    function automatic void push_lo(int exp, int arm);
        meas_t x;
        x.exp = exp; x.arm = arm;
        lo_q.push_back(x);
    endfunction

    // Cycle counter: cycle k begins at the k-th rising edge
    initial begin
        forever begin
            @(posedge clk_6M);
            cyc = cyc + 1;
        end
    end

    // Monitor: pops expectations when the DUT shows the matching event
    initial begin
        int   last_done;
        int   last_rise;
        int   last_fall;
        logic prev_sq;
        smp_t s;
        lat_t l;
        meas_t m;
        last_done = -1; last_rise = -1; last_fall = -1; prev_sq = 1'b0;
        forever begin
            @(negedge clk_6M);
            while (smp_q.size() > 0 && smp_q[0].at <= cyc) begin
                s = smp_q.pop_front();
                if (s.at < cyc) check({s.name, "_missed"}, cyc, s.at);
                else            check(s.name, sig_val(s.sig), s.exp);
            end
            if (done === 1'b1) begin
                if (lat_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    l = lat_q.pop_front();
                    check("latency", cyc - l.load_cyc + 1, l.exp);
                end
                last_done = cyc;
            end
            if (square === 1'b1 && prev_sq == 1'b0) begin
                if (start_q.size() > 0) check("start_delay", cyc - last_done, start_q.pop_front());
                if (lo_q.size() > 0 && last_fall > lo_q[0].arm) begin
                    m = lo_q.pop_front();
                    check("low_time", cyc - last_fall, m.exp);
                end
                last_rise = cyc;
            end
            if (square === 1'b0 && prev_sq == 1'b1) begin
                if (hi_q.size() > 0 && last_rise > hi_q[0].arm) begin
                    m = hi_q.pop_front();
                    check("high_time", cyc - last_rise, m.exp);
                end
                last_fall = cyc;
            end
            prev_sq = square;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_6M);
            #1;
        end
    endtask

    task automatic do_load(input logic [11:0] v, output int m);
        bcd_freq = v;
        load     = 1'b1;
        m        = cyc;
        tick(1);
        load     = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                return;
            end
            tick(1);
        end
        check("done_timeout", 0, 1);
        dc = cyc;
    endtask

    task automatic wait_rise(output int r);
        logic p;
        p = square;
        r = -1;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if (square === 1'b1 && p == 1'b0) begin
                r = cyc;
                return;
            end
            p = square;
        end
        check("rise_timeout", 0, 1);
        r = cyc;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (lat_q.size() == 0 && hi_q.size() == 0 && lo_q.size() == 0 &&
                start_q.size() == 0 && smp_q.size() == 0) return;
            tick(1);
        end
        check("drain_timeout", lat_q.size() + hi_q.size() + lo_q.size() + start_q.size() + smp_q.size(), 0);
        lat_q.delete(); hi_q.delete(); lo_q.delete(); start_q.delete(); smp_q.delete();
    endtask

    initial begin
        #(10 * 100_000);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        int m, m2, dc, r;
        // Reset values
        tick(3);
        reset = 1'b0;
        smp("rst_square", 0, 0, cyc + 1);
        smp("rst_busy",   1, 0, cyc + 1);
        smp("rst_err",    2, 0, cyc + 1);
        smp("rst_done",   3, 0, cyc + 1);
        drain(10);

        // Reset in the middle of the divide discards the conversion
        do_load(12'h100, m);
        tick(14);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        smp("midrst_square", 0, 0, cyc + 1);
        smp("midrst_busy",   1, 0, cyc + 1);
        smp("midrst_err",    2, 0, cyc + 1);
        tick(60);
        drain(10);

        // 100 Hz from stopped: half 300, starts one cycle after done
        do_load(12'h100, m);
        push_lat(LAT, m);
        start_q.push_back(1);
        push_hi(300, m);
        push_lo(300, m);
        smp("busy_running", 1, 1, m + 10);
        wait_done(dc);
        drain(3000);

        // Change to 50 Hz mid high-phase: current half completes at 300, then 600
        wait_rise(r);
        tick(9);
        do_load(12'h050, m);
        push_lat(LAT, m);
        push_hi(300, r - 1);
        push_lo(600, m);
        push_hi(600, m);
        drain(5000);

        // Invalid BCD: error after 2 cycles, no done, frequency unchanged
        do_load(12'h1A5, m);
        smp("bad_busy1", 1, 1, m + 1);
        smp("bad_busy0", 1, 0, m + 2);
        smp("bad_err",   2, 1, m + 2);
        smp("bad_err_sticky", 2, 1, m + 40);
        push_hi(600, m);
        drain(3000);

        // Valid load clears the error flag
        do_load(12'h050, m);
        smp("err_clear", 2, 0, m + 1);
        push_lat(LAT, m);
        wait_done(dc);
        push_hi(600, dc);
        drain(3000);

        // 17 Hz: truncation vs rounding
        do_load(12'h017, m);
        push_lat(LAT, m);
        wait_done(dc);
        push_hi(H17, dc);
        push_lo(H17, dc);
        drain(8000);

        // Second load while busy is ignored
        do_load(12'h100, m);
        tick(4);
        do_load(12'h003, m2);
        push_lat(LAT, m);
        wait_done(dc);
        push_hi(300, dc);
        push_lo(300, dc);
        drain(3000);
        tick(50);

        // 0 Hz while running: current high phase finishes, then stays low
        wait_rise(r);
        tick(9);
        do_load(12'h000, m);
        push_lat(LAT0, m);
        push_hi(300, r - 1);
        smp("stop_square_a", 0, 0, r + 400);
        smp("stop_busy",     1, 0, r + 400);
        smp("stop_square_b", 0, 0, r + 1200);
        drain(3000);

        // 999 Hz restart from stopped: half 30
        do_load(12'h999, m);
        push_lat(LAT, m);
        start_q.push_back(1);
        push_hi(30, m);
        push_lo(30, m);
        drain(500);

        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
